// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-wait / taken-branch stall controller for a 3-stage pipeline.
// Define HAZARD_STALL_CNT_EN to add the stall_cycles / bubble_cycles counters.
module hazard_stall_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] ifd_rs1_addr,
    input  logic [4:0] ifd_rs2_addr,
    input  logic       ifd_uses_rs1,
    input  logic       ifd_uses_rs2,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_is_load,
    input  logic       ex_branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       stall,
    output logic       pc_hold,
    output logic       bubble,
    output logic       flush,
    output logic [1:0] ctrl_state
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDUSE   = 2'd1,
        MEMWAIT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   hazard, mem_wait;

    assign hazard = ex_is_load && (ex_rd_addr != 5'd0) &&
                    ((ifd_uses_rs1 && (ifd_rs1_addr == ex_rd_addr)) ||
                     (ifd_uses_rs2 && (ifd_rs2_addr == ex_rd_addr)));
    assign mem_wait = dmem_req && !dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = RUN;
        stall     = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        // Outputs are forced quiet while reset is held, independent of inputs.
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        flush     = 1'b1;
                        bubble    = 1'b1;
                        state_nxt = FLUSH;
                    end else if (mem_wait) begin
                        stall     = 1'b1;
                        state_nxt = MEMWAIT;
                    end else if (hazard) begin
                        stall     = 1'b1;
                        state_nxt = LDUSE;
                    end
                end
                LDUSE: bubble = 1'b1;
                // EX is frozen here, so a taken branch is re-seen once back in RUN.
                MEMWAIT: begin
                    stall     = !dmem_ready;
                    state_nxt = dmem_ready ? RUN : MEMWAIT;
                end
                FLUSH: begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign pc_hold    = stall;
    assign ctrl_state = state;

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= 32'd0;
            bubble_cycles <= 32'd0;
        end else begin
            if (stall)  stall_cycles  <= stall_cycles + 32'd1;
            if (bubble) bubble_cycles <= bubble_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; expectations queued on drive, checked mid-cycle.
module tb_hazard_stall_ctrl;

    logic       clk, rst_n;
    logic [4:0] ifd_rs1_addr, ifd_rs2_addr, ex_rd_addr;
    logic       ifd_uses_rs1, ifd_uses_rs2, ex_is_load, ex_branch_taken;
    logic       dmem_req, dmem_ready;
    logic       stall, pc_hold, bubble, flush;
    logic [1:0] ctrl_state;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles, bubble_cycles;
`endif

    hazard_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ifd_rs1_addr(ifd_rs1_addr), .ifd_rs2_addr(ifd_rs2_addr),
        .ifd_uses_rs1(ifd_uses_rs1), .ifd_uses_rs2(ifd_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall(stall), .pc_hold(pc_hold), .bubble(bubble), .flush(flush),
        .ctrl_state(ctrl_state)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  tests = 0;
    int  fails = 0;

    function automatic logic [63:0] outv();
        return {58'd0, stall, pc_hold, bubble, flush, ctrl_state};
    endfunction

    // exp layout: {stall, pc_hold, bubble, flush, state[1:0]}
    task automatic push(input string tag, input logic [5:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = {58'd0, exp};
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [63:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_empty observed=%h required=entry", obs);
            return;
        end
        e = sb_q.pop_front();
        tests++;
        assert (obs === e.exp) else begin
            fails++;
            $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic ld, input logic br, input logic req, input logic rdy);
        ifd_rs1_addr = rs1; ifd_rs2_addr = rs2;
        ifd_uses_rs1 = u1;  ifd_uses_rs2 = u2;
        ex_rd_addr = rd; ex_is_load = ld; ex_branch_taken = br;
        dmem_req = req; dmem_ready = rdy;
    endtask

    // Called at posedge+1: check mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [5:0] exp);
        push(tag, exp);
        #4;
        pop_cmp(outv());
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        // Hazard inputs active during reset: outputs must still read zero.
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        #3;
        push("reset", 6'b000000);
        pop_cmp(outv());
        @(posedge clk); #2;
        push("reset_clk", 6'b000000);
        pop_cmp(outv());
        idle();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use on rs2
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_stall",  6'b110000);
        step("lu_bubble", 6'b001001);
        idle();
        step("lu_run",    6'b000000);

        // x0 is never a hazard
        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("x0_a", 6'b000000);
        step("x0_b", 6'b000000);

        // Memory wait of 3 cycles; a branch during MEMWAIT is ignored
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mw_run",  6'b110000);
        step("mw_w1",   6'b110010);
        ex_branch_taken = 1'b1;
        step("mw_w2br", 6'b110010);
        ex_branch_taken = 1'b0;
        dmem_ready = 1'b1;
        step("mw_rel",  6'b000010);
        idle();
        step("mw_run2", 6'b000000);

`ifdef HAZARD_STALL_CNT_EN
        push("stall_cnt", 6'd4);
        pop_cmp({32'd0, stall_cycles} & 64'h3F);
        push("bubble_cnt", 6'd1);
        pop_cmp({32'd0, bubble_cycles} & 64'h3F);
`endif

        // Branch + hazard + memory wait together: branch wins
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        step("br_all",   6'b001100);
        idle();
        step("br_flush", 6'b001111);
        step("br_run",   6'b000000);

        // Reset in MEMWAIT
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rw_run", 6'b110000);
        push("rw_wait", 6'b110010);
        #2;
        pop_cmp(outv());
        rst_n = 1'b0;
        #1;
        push("rw_reset", 6'b000000);
        pop_cmp(outv());
        idle();
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step("rw_after", 6'b000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifd_rs1_addr  in  5  rs1 of the instruction in IF/D.
- ifd_rs2_addr  in  5  rs2 of the instruction in IF/D.
- ifd_uses_rs1  in  1  IF/D instruction reads rs1.
- ifd_uses_rs2  in  1  IF/D instruction reads rs2.
- ex_rd_addr  in  5  destination register of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- dmem_req  in  1  EX issues a data-memory access this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall  out  1  drives the stall input of the IF/D-to-EX register; freezes IF/D.
- pc_hold  out  1  PC keeps its value.
- bubble  out  1  EX latches a NOP (0x00000013) instead of the IF/D instruction.
- flush  out  1  squashes the wrong-path instruction fetched after a taken branch.
- ctrl_state  out  2  current state encoding.
REQ-002 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.

Function
REQ-003 The block SHALL use a registered FSM with states RUN=2'd0, LDUSE=2'd1, MEMWAIT=2'd2, FLUSH=2'd3, and ctrl_state SHALL equal the state register.
REQ-004 The hazard term SHALL be true when ex_is_load=1, ex_rd_addr!=0, and either (ifd_uses_rs1 and ifd_rs1_addr==ex_rd_addr) or (ifd_uses_rs2 and ifd_rs2_addr==ex_rd_addr).
REQ-005 The memory-wait term SHALL be true when dmem_req=1 and dmem_ready=0.
REQ-006 In RUN, the event priority SHALL be ex_branch_taken, then memory wait, then hazard, then no event.
REQ-007 RUN outputs and next state by event:
- ex_branch_taken: flush=1, bubble=1, next FLUSH.
- memory wait: stall=1, pc_hold=1, next MEMWAIT.
- hazard: stall=1, pc_hold=1, next LDUSE.
- no event: all outputs 0, stay in RUN.
REQ-008 In LDUSE, the block SHALL drive stall=0, pc_hold=0 and bubble=1 for exactly one cycle, then go to RUN, so that a load-use pair costs exactly one bubble.
REQ-009 In MEMWAIT, the block SHALL hold stall=1 and pc_hold=1 while dmem_ready=0. When dmem_ready=1 it SHALL drop stall and pc_hold in that same cycle and go to RUN.
REQ-010 In FLUSH, the block SHALL drive flush=1, bubble=1, stall=0 and pc_hold=0 for one cycle, then go to RUN; this gives two squashed slots per taken branch.
REQ-011 ex_branch_taken arriving in MEMWAIT SHALL be ignored until MEMWAIT exits; the EX instruction is frozen, so the branch is re-evaluated in RUN.
REQ-012 stall and pc_hold SHALL always be equal; bubble and stall SHALL never both be 1.
REQ-013 Outputs SHALL be combinational from the state and the current inputs, with zero-cycle latency from hazard detection to stall.
REQ-014 An unreachable state encoding, if ever reached, SHALL go to RUN with all outputs 0.

Reset
REQ-015 While rst_n=0, the state SHALL be RUN and stall, pc_hold, bubble, flush and ctrl_state SHALL all be 0, regardless of clk.
REQ-016 Reset asserted in any state SHALL abandon that state immediately. After release, the first rising edge SHALL evaluate from RUN.

Configuration
REQ-017 When the macro HAZARD_STALL_CNT_EN is defined, the block SHALL add these outputs:
- stall_cycles (32-bit): increments on every clock edge where stall=1.
- bubble_cycles (32-bit): increments on every clock edge where bubble=1.
REQ-018 Both counters SHALL reset to 0 on rst_n=0 and wrap from 0xFFFFFFFF to 0.
REQ-019 When HAZARD_STALL_CNT_EN is not defined, the counters and their ports SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-020 Load-use: ex_is_load=1, ex_rd_addr=5, ifd_rs2_addr=5, ifd_uses_rs2=1 -> stall=1 in that cycle; next cycle bubble=1, stall=0, state LDUSE; then RUN.
REQ-021 x0 is not a hazard: ex_is_load=1, ex_rd_addr=0, ifd_rs1_addr=0, ifd_uses_rs1=1 -> stall=0, state stays RUN.
REQ-022 Memory wait: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 -> stall=1 for exactly 3 cycles, released in the cycle dmem_ready=1, state MEMWAIT then RUN.
REQ-023 Simultaneous events: ex_branch_taken=1 together with a hazard and a memory wait -> flush=1, bubble=1, stall=0; next cycle state FLUSH with flush=1; then RUN.
REQ-024 Reset mid-wait: assert rst_n=0 while in MEMWAIT -> all outputs 0 immediately, ctrl_state=0.
REQ-025 Counters, with HAZARD_STALL_CNT_EN defined: after REQ-020 followed by REQ-022 -> stall_cycles=4 and bubble_cycles=1.
